// File: rtl/game_pkg.sv
// Shared state encoding, sizes and the saturating score helper used by the
// game sequencer and its timing divider.
package game_pkg;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_PLAY = 2'd1,
        S_LOSE = 2'd2
    } state_e;

    localparam int COIN_SLOTS = 5;
    localparam int SCORE_MAX  = 15;
    localparam int SCORE_W    = 4;

    // Holds at SCORE_MAX instead of wrapping back to zero.
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_W'(SCORE_MAX)) ? s : s + 1'b1;
    endfunction

endpackage

// File: rtl/game_sequencer_tick_div.sv
// Enabled modulo-DIV counter; tick is high on the last count of each period.
// Dropping en clears the count so every enabled stretch starts from zero.
module tick_div #(
    parameter int DIV = 4
) (
    input  logic Clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/game_sequencer.sv
// Top-level game flow controller: INIT/PLAY/LOSE sequencing, coin scoring,
// scroll timing and the lose-screen flash, with every output registered.
module game_sequencer
    import game_pkg::*;
#(
    parameter int TICK_DIV  = 524288,
    parameter int FLASH_DIV = 4194304
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  BtnC,
    input  logic                  Collide,
    input  logic                  Coin_Hit,
    input  logic                  Pipe_Shift,
    output logic                  Run,
    output logic                  Scroll_Tick,
    output logic [COIN_SLOTS-1:0] Show_Coin,
    output logic [SCORE_W-1:0]    Score,
    output logic                  Q_Init,
    output logic                  Q_Play,
    output logic                  Q_Lose,
    output logic                  Flash
);

    state_e                state_q;
    state_e                state_d;
    logic                  btnC_q;
    logic                  btnRise;
    logic [COIN_SLOTS-1:0] coin_q;
    logic [COIN_SLOTS-1:0] coin_d;
    logic [SCORE_W-1:0]    score_q;
    logic [SCORE_W-1:0]    score_d;
    logic                  hitQual;
    logic                  run_q;
    logic                  scroll_q;
    logic                  flash_q;
    logic                  qInit_q;
    logic                  qPlay_q;
    logic                  qLose_q;
    logic                  scrollEn;
    logic                  flashEn;
    logic                  scrollStrobe;
    logic                  flashStrobe;

    assign btnRise = BtnC & ~btnC_q;
    assign hitQual = Coin_Hit & coin_q[0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  if (btnRise) state_d = S_PLAY;
            S_PLAY:  if (Collide) state_d = S_LOSE;
            S_LOSE:  if (btnRise) state_d = S_INIT;
            default: state_d = S_INIT;
        endcase
    end

    // Only the PLAY cycles that stay in PLAY see coin events, so a collision
    // swallows any hit or shift arriving alongside it.
    always_comb begin
        coin_d  = coin_q;
        score_d = score_q;
        if (state_d == S_INIT) begin
            coin_d  = '1;
            score_d = '0;
        end else if ((state_q == S_PLAY) && !Collide) begin
            if (Pipe_Shift) begin
                coin_d = {1'b1, coin_q[COIN_SLOTS-1:1]};
            end else if (hitQual) begin
                coin_d[0] = 1'b0;
            end
            if (hitQual) begin
                score_d = score_inc(score_q);
            end
        end
    end

    // Dividers run only while the state is and stays the same, which zeroes
    // them on entry and keeps strobes from leaking into the next state.
    assign scrollEn = (state_q == S_PLAY) && (state_d == S_PLAY);
    assign flashEn  = (state_q == S_LOSE) && (state_d == S_LOSE);

    tick_div #(
        .DIV (TICK_DIV)
    ) u_scroll_div (
        .Clk   (Clk),
        .reset (reset),
        .en    (scrollEn),
        .tick  (scrollStrobe)
    );

    tick_div #(
        .DIV (FLASH_DIV)
    ) u_flash_div (
        .Clk   (Clk),
        .reset (reset),
        .en    (flashEn),
        .tick  (flashStrobe)
    );

    // The button history resets high so a press held through reset is not a rise.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q  <= S_INIT;
            btnC_q   <= 1'b1;
            coin_q   <= '1;
            score_q  <= '0;
            run_q    <= 1'b0;
            scroll_q <= 1'b0;
            flash_q  <= 1'b0;
            qInit_q  <= 1'b1;
            qPlay_q  <= 1'b0;
            qLose_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            btnC_q   <= BtnC;
            coin_q   <= coin_d;
            score_q  <= score_d;
            run_q    <= (state_d == S_PLAY);
            scroll_q <= scrollStrobe;
            flash_q  <= flashEn ? (flash_q ^ flashStrobe) : 1'b0;
            qInit_q  <= (state_d == S_INIT);
            qPlay_q  <= (state_d == S_PLAY);
            qLose_q  <= (state_d == S_LOSE);
        end
    end

    assign Run         = run_q;
    assign Scroll_Tick = scroll_q;
    assign Show_Coin   = coin_q;
    assign Score       = score_q;
    assign Q_Init      = qInit_q;
    assign Q_Play      = qPlay_q;
    assign Q_Lose      = qLose_q;
    assign Flash       = flash_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scenario bench for game_sequencer with short dividers; expected output
// words are queued as each stimulus is applied and popped after the clock edge.
module tb_game_sequencer;

    localparam int TICK_DIV  = 4;
    localparam int FLASH_DIV = 3;
    localparam logic [14:0] FULL   = 15'h7FFF;
    localparam logic [14:0] NOTICK = 15'h7BFF;

    logic       Clk = 1'b0;
    logic       reset;
    logic       BtnC;
    logic       Collide;
    logic       Coin_Hit;
    logic       Pipe_Shift;
    logic       Run;
    logic       Scroll_Tick;
    logic [4:0] Show_Coin;
    logic [3:0] Score;
    logic       Q_Init;
    logic       Q_Play;
    logic       Q_Lose;
    logic       Flash;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        string       tag;
        logic [14:0] v;
        logic [14:0] m;
    } exp_t;

    exp_t expQ[$];

    logic [14:0] obsVec;
    assign obsVec = {Q_Init, Q_Play, Q_Lose, Run, Scroll_Tick, Flash, Score, Show_Coin};

    game_sequencer #(
        .TICK_DIV  (TICK_DIV),
        .FLASH_DIV (FLASH_DIV)
    ) dut (
        .Clk         (Clk),
        .reset       (reset),
        .BtnC        (BtnC),
        .Collide     (Collide),
        .Coin_Hit    (Coin_Hit),
        .Pipe_Shift  (Pipe_Shift),
        .Run         (Run),
        .Scroll_Tick (Scroll_Tick),
        .Show_Coin   (Show_Coin),
        .Score       (Score),
        .Q_Init      (Q_Init),
        .Q_Play      (Q_Play),
        .Q_Lose      (Q_Lose),
        .Flash       (Flash)
    );

    always #5 Clk = ~Clk;

    function automatic logic [14:0] vInit();
        return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'h1F};
    endfunction

    function automatic logic [14:0] vPlay(input logic tk, input logic [3:0] sc, input logic [4:0] cn);
        return {1'b0, 1'b1, 1'b0, 1'b1, tk, 1'b0, sc, cn};
    endfunction

    function automatic logic [14:0] vLose(input logic fl, input logic [3:0] sc, input logic [4:0] cn);
        return {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, fl, sc, cn};
    endfunction

    task automatic applyStimulus(input logic r, input logic b, input logic c,
                                 input logic h, input logic s);
        reset      = r;
        BtnC       = b;
        Collide    = c;
        Coin_Hit   = h;
        Pipe_Shift = s;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0, 1:    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
                2, 3, 4: applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                5:       applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                default: applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            endcase
            if (i == 6) expQ.push_back('{tag: "start_on_rise", v: vPlay(1'b0, 4'd0, 5'h1F), m: FULL});
            else        expQ.push_back('{tag: $sformatf("reset_hold[%0d]", i), v: vInit(), m: FULL});
            tick();
            e = expQ.pop_front();
            testsRun++;
            if ((obsVec & e.m) !== (e.v & e.m)) begin
                testsFailed++;
                $display("[TB] FAIL %s: observed %h, expected %h", e.tag, obsVec & e.m, e.v & e.m);
            end
        end
    endtask

    task automatic test_scroll();
        exp_t e;
        for (int j = 1; j <= 12; j++) begin
            applyStimulus(1'b0, j[0], 1'b0, 1'b0, 1'b0);
            expQ.push_back('{tag: $sformatf("scroll[%0d]", j),
                             v: vPlay((j % 4) == 0, 4'd0, 5'h1F), m: FULL});
            tick();
            e = expQ.pop_front();
            testsRun++;
            if ((obsVec & e.m) !== (e.v & e.m)) begin
                testsFailed++;
                $display("[TB] FAIL %s: observed %h, expected %h", e.tag, obsVec & e.m, e.v & e.m);
            end
        end
    endtask

    task automatic test_coin_hit();
        exp_t e;
        for (int j = 0; j < 7; j++) begin
            if (j < 5) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                expQ.push_back('{tag: $sformatf("hold_hit[%0d]", j), v: vPlay(1'b0, 4'd1, 5'h1E), m: NOTICK});
            end else if (j == 5) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                expQ.push_back('{tag: "shift_refill", v: vPlay(1'b0, 4'd1, 5'h1F), m: NOTICK});
            end else begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                expQ.push_back('{tag: "idle_hold", v: vPlay(1'b0, 4'd1, 5'h1F), m: NOTICK});
            end
            tick();
            e = expQ.pop_front();
            testsRun++;
            if ((obsVec & e.m) !== (e.v & e.m)) begin
                testsFailed++;
                $display("[TB] FAIL %s: observed %h, expected %h", e.tag, obsVec & e.m, e.v & e.m);
            end
        end
    endtask

    task automatic test_hit_and_shift();
        exp_t e;
        for (int j = 0; j < 3; j++) begin
            case (j)
                0: begin
                    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
                    expQ.push_back('{tag: "both_full", v: vPlay(1'b0, 4'd2, 5'h1F), m: NOTICK});
                end
                1: begin
                    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                    expQ.push_back('{tag: "clear_lead", v: vPlay(1'b0, 4'd3, 5'h1E), m: NOTICK});
                end
                default: begin
                    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
                    expQ.push_back('{tag: "both_empty_lead", v: vPlay(1'b0, 4'd3, 5'h1F), m: NOTICK});
                end
            endcase
            tick();
            e = expQ.pop_front();
            testsRun++;
            if ((obsVec & e.m) !== (e.v & e.m)) begin
                testsFailed++;
                $display("[TB] FAIL %s: observed %h, expected %h", e.tag, obsVec & e.m, e.v & e.m);
            end
        end
    endtask

    task automatic test_lose();
        exp_t e;
        for (int j = 0; j <= 10; j++) begin
            if (j == 0) begin
                applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
                expQ.push_back('{tag: "collide_priority", v: vLose(1'b0, 4'd3, 5'h1F), m: FULL});
            end else if (j <= 9) begin
                applyStimulus(1'b0, 1'b0, j[0], j[1], j[0] ^ j[1]);
                expQ.push_back('{tag: $sformatf("flash[%0d]", j),
                                 v: vLose(((j / 3) % 2) == 1, 4'd3, 5'h1F), m: FULL});
            end else begin
                applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                expQ.push_back('{tag: "lose_exit", v: vInit(), m: FULL});
            end
            tick();
            e = expQ.pop_front();
            testsRun++;
            if ((obsVec & e.m) !== (e.v & e.m)) begin
                testsFailed++;
                $display("[TB] FAIL %s: observed %h, expected %h", e.tag, obsVec & e.m, e.v & e.m);
            end
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        for (int j = -1; j <= 18; j++) begin
            if (j == -1) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                expQ.push_back('{tag: "sat_release", v: vInit(), m: FULL});
            end else if (j == 0) begin
                applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                expQ.push_back('{tag: "sat_start", v: vPlay(1'b0, 4'd0, 5'h1F), m: FULL});
            end else if (j <= 16) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
                expQ.push_back('{tag: $sformatf("sat_hit[%0d]", j),
                                 v: vPlay(1'b0, (j > 15) ? 4'd15 : 4'(j), 5'h1F), m: NOTICK});
            end else if (j == 17) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                expQ.push_back('{tag: "sat_hit_alone", v: vPlay(1'b0, 4'd15, 5'h1E), m: NOTICK});
            end else begin
                applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
                expQ.push_back('{tag: "reset_mid_play", v: vInit(), m: FULL});
            end
            tick();
            e = expQ.pop_front();
            testsRun++;
            if ((obsVec & e.m) !== (e.v & e.m)) begin
                testsFailed++;
                $display("[TB] FAIL %s: observed %h, expected %h", e.tag, obsVec & e.m, e.v & e.m);
            end
        end
    endtask

    task automatic test_reset_mid_lose();
        exp_t e;
        for (int j = 0; j < 8; j++) begin
            case (j)
                0: begin
                    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                    expQ.push_back('{tag: "post_reset_held", v: vInit(), m: FULL});
                end
                1: begin
                    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                    expQ.push_back('{tag: "post_reset_release", v: vInit(), m: FULL});
                end
                2: begin
                    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                    expQ.push_back('{tag: "restart", v: vPlay(1'b0, 4'd0, 5'h1F), m: FULL});
                end
                3: begin
                    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                    expQ.push_back('{tag: "collide_again", v: vLose(1'b0, 4'd0, 5'h1F), m: FULL});
                end
                4, 5, 6: begin
                    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                    expQ.push_back('{tag: $sformatf("lose_wait[%0d]", j - 3),
                                     v: vLose(j == 6, 4'd0, 5'h1F), m: FULL});
                end
                default: begin
                    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                    expQ.push_back('{tag: "reset_mid_lose", v: vInit(), m: FULL});
                end
            endcase
            tick();
            e = expQ.pop_front();
            testsRun++;
            if ((obsVec & e.m) !== (e.v & e.m)) begin
                testsFailed++;
                $display("[TB] FAIL %s: observed %h, expected %h", e.tag, obsVec & e.m, e.v & e.m);
            end
        end
    endtask

    initial begin
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        test_reset();
        test_scroll();
        test_coin_hit();
        test_hit_and_shift();
        test_lose();
        test_saturate();
        test_reset_mid_lose();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
